// File: rtl/rv_imem_arb_if.sv
// rv_imem_arb_if: fetch, host and memory-macro signals of the instruction memory arbiter
//   slave  : arbiter side (rv_imem_arb)
//   master : environment side (fetch unit, host/loader, memory macro)
interface rv_imem_arb_if;
  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic        f_hold_i;
  logic        h_req_i;
  logic        h_we_i;
  logic [31:0] h_addr_i;
  logic [31:0] h_wdata_i;
  logic        h_ack_o;
  logic [31:0] h_rdata_o;
  logic [31:0] mem_addr_o;
  logic        mem_wr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_data_i;
  logic [31:0] stolen_cnt_o;
  modport slave (
    input  im_addr_i, f_hold_i, h_req_i, h_we_i, h_addr_i, h_wdata_i, mem_data_i,
    output im_data_o, im_valid_o, h_ack_o, h_rdata_o, mem_addr_o, mem_wr_o, mem_wdata_o, stolen_cnt_o
  );
  modport master (
    output im_addr_i, f_hold_i, h_req_i, h_we_i, h_addr_i, h_wdata_i, mem_data_i,
    input  im_data_o, im_valid_o, h_ack_o, h_rdata_o, mem_addr_o, mem_wr_o, mem_wdata_o, stolen_cnt_o
  );
endinterface

// File: rtl/rv_imem_arb.sv
// rv_imem_arb: shares one single-ported 1-cycle instruction memory between fetch (priority) and a host port
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : rv_imem_arb_if.slave (fetch im_*, host h_*, memory mem_*, stolen_cnt_o)
//   URV_IMEM_ARB_STATS_EN : when defined, stolen_cnt_o counts host slots taken from an active fetch
module rv_imem_arb #(
  parameter int unsigned HOST_WAIT_MAX = 4
) (
  input logic          clk_i,
  input logic          rst_n_i,
  rv_imem_arb_if.slave bus
);
  typedef enum logic [1:0] {NONE, FETCH, HOST} owner_e;
  localparam logic [7:0] WMAX = 8'(HOST_WAIT_MAX);
  owner_e     owner_q, owner_d;
  logic       we_q, we_d;
  logic [7:0] wait_q, wait_d;
  logic       host_grant;
  always_comb begin
    host_grant = bus.h_req_i && (bus.f_hold_i || wait_q == WMAX) && owner_q != HOST;
    owner_d    = host_grant ? HOST : FETCH;
    we_d       = host_grant & bus.h_we_i;
    // the ack cycle still carries the completed request, so waiting restarts after it
    wait_d     = (!bus.h_req_i || host_grant || owner_q == HOST) ? 8'd0 :
                 (wait_q < WMAX ? wait_q + 8'd1 : wait_q);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q <= NONE;
      we_q    <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
    end
  end
  assign bus.mem_addr_o  = host_grant ? bus.h_addr_i : bus.im_addr_i;
  assign bus.mem_wr_o    = host_grant & bus.h_we_i;
  assign bus.mem_wdata_o = bus.h_wdata_i;
  assign bus.im_data_o   = bus.mem_data_i;
  assign bus.im_valid_o  = owner_q == FETCH;
  assign bus.h_ack_o     = owner_q == HOST;
  assign bus.h_rdata_o   = (owner_q == HOST && !we_q) ? bus.mem_data_i : 32'd0;
`ifdef URV_IMEM_ARB_STATS_EN
  logic [31:0] stolen_q, stolen_d;
  always_comb stolen_d = stolen_q + 32'(host_grant && !bus.f_hold_i);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stolen_q <= 32'd0;
    else stolen_q <= stolen_d;
  end
  assign bus.stolen_cnt_o = stolen_q;
`else
  assign bus.stolen_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_rv_imem_arb.sv
// tb_rv_imem_arb: directed checks of rv_imem_arb with a 1-cycle memory model
module tb_rv_imem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mem [0:255];
  logic [19:0] steal;
  logic prev;
`ifdef URV_IMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  rv_imem_arb_if bus();
  rv_imem_arb #(.HOST_WAIT_MAX(4)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_wr_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
    bus.mem_data_i <= mem[bus.mem_addr_o[9:2]];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | (i << 2);
    mem[64] = 32'hDEAD_BEEF;
    bus.im_addr_i = 32'h0;
    bus.f_hold_i  = 1'b0;
    bus.h_req_i   = 1'b0;
    bus.h_we_i    = 1'b0;
    bus.h_addr_i  = 32'h0;
    bus.h_wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.im_valid_o}, 32'd0);
    chk("rst_ack", {31'd0, bus.h_ack_o}, 32'd0);
    chk("rst_stolen", bus.stolen_cnt_o, 32'd0);
    chk("rst_rdata", bus.h_rdata_o, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_valid", {31'd0, bus.im_valid_o}, 32'd0);
    tick();
    chk("f0_valid", {31'd0, bus.im_valid_o}, 32'd1);
    chk("f0_data", bus.im_data_o, 32'hC0DE_0000);
    chk("f0_ack", {31'd0, bus.h_ack_o}, 32'd0);
    bus.im_addr_i = 32'h4;
    tick();
    chk("f4_data", bus.im_data_o, 32'hC0DE_0004);
    bus.im_addr_i = 32'h8;
    tick();
    chk("f8_data", bus.im_data_o, 32'hC0DE_0008);
    chk("f8_ack", {31'd0, bus.h_ack_o}, 32'd0);
    bus.f_hold_i = 1'b1;
    bus.h_req_i  = 1'b1;
    bus.h_addr_i = 32'h100;
    #1;
    chk("hr_addr", bus.mem_addr_o, 32'h100);
    chk("hr_wr", {31'd0, bus.mem_wr_o}, 32'd0);
    tick();
    chk("hr_ack", {31'd0, bus.h_ack_o}, 32'd1);
    chk("hr_rdata", bus.h_rdata_o, 32'hDEAD_BEEF);
    chk("hr_valid", {31'd0, bus.im_valid_o}, 32'd0);
    bus.h_req_i  = 1'b0;
    bus.f_hold_i = 1'b0;
    tick();
    chk("hr_ack_end", {31'd0, bus.h_ack_o}, 32'd0);
    chk("hr_refetch", bus.im_data_o, 32'hC0DE_0008);
    chk("hr_revalid", {31'd0, bus.im_valid_o}, 32'd1);
    chk("hr_rdata0", bus.h_rdata_o, 32'd0);
    chk("hr_stolen", bus.stolen_cnt_o, 32'd0);
    bus.h_req_i   = 1'b1;
    bus.h_we_i    = 1'b1;
    bus.h_addr_i  = 32'h200;
    bus.h_wdata_i = 32'h1234_5678;
    bus.im_addr_i = 32'hC;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hw_wait_wr", {31'd0, bus.mem_wr_o}, 32'd0);
      chk("hw_wait_addr", bus.mem_addr_o, 32'hC);
      tick();
    end
    #1;
    chk("hw_wr", {31'd0, bus.mem_wr_o}, 32'd1);
    chk("hw_addr", bus.mem_addr_o, 32'h200);
    chk("hw_wdata", bus.mem_wdata_o, 32'h1234_5678);
    tick();
    chk("hw_ack", {31'd0, bus.h_ack_o}, 32'd1);
    chk("hw_rdata", bus.h_rdata_o, 32'd0);
    chk("hw_valid", {31'd0, bus.im_valid_o}, 32'd0);
    bus.h_req_i   = 1'b0;
    bus.h_we_i    = 1'b0;
    bus.im_addr_i = 32'h200;
    #1;
    chk("hw_wr_once", {31'd0, bus.mem_wr_o}, 32'd0);
    chk("hw_fetch_addr", bus.mem_addr_o, 32'h200);
    tick();
    chk("hw_fetch_valid", {31'd0, bus.im_valid_o}, 32'd1);
    chk("hw_fetch_data", bus.im_data_o, 32'h1234_5678);
    chk("hw_stolen", bus.stolen_cnt_o, STATS ? 32'd1 : 32'd0);
    bus.h_req_i   = 1'b1;
    bus.h_addr_i  = 32'h100;
    bus.im_addr_i = 32'h10;
    steal = 20'h10410;
    prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("held_addr%0d", c), bus.mem_addr_o, steal[c] ? 32'h100 : 32'h10);
      chk($sformatf("held_ack%0d", c), {31'd0, bus.h_ack_o}, {31'd0, prev});
      if (prev) chk($sformatf("held_rdata%0d", c), bus.h_rdata_o, 32'hDEAD_BEEF);
      else if (c > 0) chk($sformatf("held_fdata%0d", c), bus.im_data_o, 32'hC0DE_0010);
      prev = steal[c];
      tick();
    end
    chk("held_ack_end", {31'd0, bus.h_ack_o}, {31'd0, prev});
    chk("held_stolen", bus.stolen_cnt_o, STATS ? 32'd4 : 32'd0);
    bus.h_req_i = 1'b0;
    tick();
    bus.h_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_wait_addr", bus.mem_addr_o, 32'h10);
      tick();
    end
    bus.h_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drop_addr", bus.mem_addr_o, 32'h10);
      tick();
      chk("drop_ack", {31'd0, bus.h_ack_o}, 32'd0);
    end
    chk("drop_stolen", bus.stolen_cnt_o, STATS ? 32'd4 : 32'd0);
    bus.h_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rereq_wait_addr", bus.mem_addr_o, 32'h10);
      tick();
    end
    #1;
    chk("rereq_grant_addr", bus.mem_addr_o, 32'h100);
    tick();
    chk("rereq_ack", {31'd0, bus.h_ack_o}, 32'd1);
    chk("rereq_rdata", bus.h_rdata_o, 32'hDEAD_BEEF);
    chk("rereq_stolen", bus.stolen_cnt_o, STATS ? 32'd5 : 32'd0);
    bus.h_req_i = 1'b0;
    tick();
    bus.h_req_i  = 1'b1;
    bus.f_hold_i = 1'b1;
    #1;
    chk("rst_rd_addr", bus.mem_addr_o, 32'h100);
    tick();
    chk("rst_rd_ack", {31'd0, bus.h_ack_o}, 32'd1);
    rst_n = 1'b0;
    bus.h_req_i  = 1'b0;
    bus.f_hold_i = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, bus.h_ack_o}, 32'd0);
    chk("rst_mid_valid", {31'd0, bus.im_valid_o}, 32'd0);
    chk("rst_mid_stolen", bus.stolen_cnt_o, 32'd0);
    chk("rst_mid_rdata", bus.h_rdata_o, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rel_ack", {31'd0, bus.h_ack_o}, 32'd0);
    chk("post_rel_valid", {31'd0, bus.im_valid_o}, 32'd0);
    tick();
    chk("post_first_ack", {31'd0, bus.h_ack_o}, 32'd0);
    chk("post_first_valid", {31'd0, bus.im_valid_o}, 32'd1);
    chk("post_first_data", bus.im_data_o, 32'hC0DE_0010);
    tick();
    chk("post_second_ack", {31'd0, bus.h_ack_o}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
